// File: rtl/riscv_defines.sv
`default_nettype none
// ============================================================================
// Module      : riscv_defines (package)
// Description : Shared constants and types for the write-back stage and LSU.
//               Holds default word/address widths, load-size encodings and
//               the write-back FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_defines;

  localparam int WORD_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  localparam logic [1:0] LSIZE_BYTE = 2'b00;
  localparam logic [1:0] LSIZE_HALF = 2'b01;
  localparam logic [1:0] LSIZE_WORD = 2'b10;

  typedef enum logic [0:0] {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage : riscv_defines
`default_nettype wire

// File: rtl/wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage_if (interface)
// Description : Bundle between execute/memory side and the write-back stage.
//   ex_*       : retiring instruction from execute (result / load info)
//   data_*     : data memory response
//   stall_o    : hold upstream
//   waddr/wdata/write_en : register-bank write port toward decode
//   load_err_o : load timeout pulse
//   Modport slave  : the write-back stage.
//   Modport master : the environment driving the stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_stage_if #(
  parameter int WORD_WIDTH = riscv_defines::WORD_WIDTH,
  parameter int ADDR_WIDTH = riscv_defines::ADDR_WIDTH
) ();

  logic                  ex_valid_i;
  logic [WORD_WIDTH-1:0] ex_result_i;
  logic [ADDR_WIDTH-1:0] ex_rd_i;
  logic                  ex_wen_i;
  logic                  ex_load_i;
  logic [1:0]            ex_lsize_i;
  logic                  ex_lunsigned_i;
  logic                  data_rvalid_i;
  logic [WORD_WIDTH-1:0] data_rdata_i;
  logic                  stall_o;
  logic [ADDR_WIDTH-1:0] waddr_wb_o;
  logic [WORD_WIDTH-1:0] wdata_wb_o;
  logic                  write_en_o;
  logic                  load_err_o;

  modport slave (
    input  ex_valid_i, ex_result_i, ex_rd_i, ex_wen_i, ex_load_i,
           ex_lsize_i, ex_lunsigned_i, data_rvalid_i, data_rdata_i,
    output stall_o, waddr_wb_o, wdata_wb_o, write_en_o, load_err_o
  );

  modport master (
    output ex_valid_i, ex_result_i, ex_rd_i, ex_wen_i, ex_load_i,
           ex_lsize_i, ex_lunsigned_i, data_rvalid_i, data_rdata_i,
    input  stall_o, waddr_wb_o, wdata_wb_o, write_en_o, load_err_o
  );

endinterface : wb_stage_if
`default_nettype wire

// File: rtl/wb_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Combinational load data formatter. Selects the addressed
//               byte/half from a word-aligned read word and sign- or
//               zero-extends it. Word loads pass through unchanged.
//   rdata_i    : word-aligned memory read data
//   offset_i   : byte offset within the word
//   size_i     : LSIZE_BYTE / LSIZE_HALF / LSIZE_WORD (2'b11 = word)
//   unsigned_i : 1 = zero-extend, 0 = sign-extend
//   data_o     : formatted, extended result
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
  import riscv_defines::*;
#(
  parameter int WORD_WIDTH = riscv_defines::WORD_WIDTH
) (
  input  logic [WORD_WIDTH-1:0] rdata_i,
  input  logic [1:0]            offset_i,
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  output logic [WORD_WIDTH-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[8*offset_i +: 8];
    // Half loads use only the upper offset bit; misaligned halves are not split.
    half_sel = rdata_i[16*offset_i[1] +: 16];
    data_o   = rdata_i;
    case (size_i)
      LSIZE_BYTE: data_o = {{(WORD_WIDTH-8){~unsigned_i & byte_sel[7]}}, byte_sel};
      LSIZE_HALF: data_o = {{(WORD_WIDTH-16){~unsigned_i & half_sel[15]}}, half_sel};
      default:    data_o = rdata_i;
    endcase
  end

endmodule : load_align
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage
// Description : Write-back stage. Retires ALU results in one cycle, holds the
//               pipeline while a load waits for data memory, formats load
//               data and drives the register-bank write port.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : wb_stage_if.slave (ex_*, data_*, stall_o, waddr_wb_o,
//           wdata_wb_o, write_en_o, load_err_o)
// Options     : define WB_LOAD_TIMEOUT_EN to abort loads whose response does
//               not arrive within TIMEOUT_CYCLES wait cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage
  import riscv_defines::*;
#(
  parameter int WORD_WIDTH     = riscv_defines::WORD_WIDTH,
  parameter int ADDR_WIDTH     = riscv_defines::ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  wb_stage_if.slave  bus
);

  wb_state_e             state_q;

  // Load context captured at acceptance, used while waiting for the response.
  logic [ADDR_WIDTH-1:0] ld_rd_q;
  logic                  ld_wen_q;
  logic [1:0]            ld_size_q;
  logic                  ld_uns_q;
  logic [1:0]            ld_off_q;

  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [WORD_WIDTH-1:0] wdata_q;
  logic                  we_q;

  // Formatter inputs: live ex_* in IDLE (zero-wait load), captured in WAIT_LOAD.
  logic                  in_idle;
  logic [1:0]            al_off;
  logic [1:0]            al_size;
  logic                  al_uns;
  logic [WORD_WIDTH-1:0] al_data;

  assign in_idle = (state_q == WB_IDLE);
  assign al_off  = in_idle ? bus.ex_result_i[1:0] : ld_off_q;
  assign al_size = in_idle ? bus.ex_lsize_i       : ld_size_q;
  assign al_uns  = in_idle ? bus.ex_lunsigned_i   : ld_uns_q;

  load_align #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_load_align (
    .rdata_i    (bus.data_rdata_i),
    .offset_i   (al_off),
    .size_i     (al_size),
    .unsigned_i (al_uns),
    .data_o     (al_data)
  );

`ifdef WB_LOAD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WB_IDLE;
      ld_rd_q   <= '0;
      ld_wen_q  <= 1'b0;
      ld_size_q <= LSIZE_WORD;
      ld_uns_q  <= 1'b0;
      ld_off_q  <= 2'b00;
      waddr_q   <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      we_q <= 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        WB_IDLE: begin
          if (bus.ex_valid_i) begin
            if (!bus.ex_load_i) begin
              waddr_q <= bus.ex_rd_i;
              wdata_q <= bus.ex_result_i;
              we_q    <= bus.ex_wen_i && (bus.ex_rd_i != '0);
            end else begin
              ld_rd_q   <= bus.ex_rd_i;
              ld_wen_q  <= bus.ex_wen_i;
              ld_size_q <= bus.ex_lsize_i;
              ld_uns_q  <= bus.ex_lunsigned_i;
              ld_off_q  <= bus.ex_result_i[1:0];
              if (bus.data_rvalid_i) begin
                waddr_q <= bus.ex_rd_i;
                wdata_q <= al_data;
                we_q    <= bus.ex_wen_i && (bus.ex_rd_i != '0);
              end else begin
                state_q <= WB_WAIT_LOAD;
`ifdef WB_LOAD_TIMEOUT_EN
                cnt_q   <= '0;
`endif
              end
            end
          end
        end

        WB_WAIT_LOAD: begin
          // A response arriving in the timeout cycle still completes normally.
          if (bus.data_rvalid_i) begin
            waddr_q <= ld_rd_q;
            wdata_q <= al_data;
            we_q    <= ld_wen_q && (ld_rd_q != '0);
            state_q <= WB_IDLE;
`ifdef WB_LOAD_TIMEOUT_EN
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // This wait cycle is the TIMEOUT_CYCLES-th without a response.
            cnt_q   <= CNT_W'(TIMEOUT_CYCLES);
            err_q   <= 1'b1;
            state_q <= WB_IDLE;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
`endif
          end
        end

        default: state_q <= WB_IDLE;
      endcase
    end
  end

  assign bus.stall_o    = (state_q == WB_WAIT_LOAD);
  assign bus.waddr_wb_o = waddr_q;
  assign bus.wdata_wb_o = wdata_q;
  assign bus.write_en_o = we_q;
`ifdef WB_LOAD_TIMEOUT_EN
  assign bus.load_err_o = err_q;
`else
  assign bus.load_err_o = 1'b0;
`endif

endmodule : wb_stage
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage
// Description : Directed self-checking bench for wb_stage. Expected register
//               writes are queued when stimulus is driven and checked when
//               write_en_o is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

  localparam int WW = 32;
  localparam int AW = 5;

  typedef struct {
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
  } wr_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  wr_t  sb[$];

  wb_stage_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) bus ();

  wb_stage #(
    .WORD_WIDTH     (WW),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [WW-1:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    sb.push_back(w);
  endtask

  // Advance one clock, sample 1 time unit later, check write strobe and data.
  task automatic step(input logic exp_we);
    wr_t w;
    @(posedge clk);
    #1;
    chk("write_en", {31'b0, bus.write_en_o}, {31'b0, exp_we});
    if (bus.write_en_o === 1'b1) begin
      chk("sb_has_entry", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb.size() > 0) begin
        w = sb.pop_front();
        chk("waddr", {27'b0, bus.waddr_wb_o}, {27'b0, w.addr});
        chk("wdata", bus.wdata_wb_o, w.data);
      end
    end
  endtask

  task automatic drive_alu(input logic [AW-1:0] rd, input logic [WW-1:0] res, input logic wen);
    bus.ex_valid_i = 1'b1;
    bus.ex_load_i  = 1'b0;
    bus.ex_rd_i    = rd;
    bus.ex_result_i = res;
    bus.ex_wen_i   = wen;
  endtask

  task automatic drive_load(input logic [AW-1:0] rd, input logic [WW-1:0] addr,
                            input logic [1:0] sz, input logic uns);
    bus.ex_valid_i     = 1'b1;
    bus.ex_load_i      = 1'b1;
    bus.ex_rd_i        = rd;
    bus.ex_result_i    = addr;
    bus.ex_wen_i       = 1'b1;
    bus.ex_lsize_i     = sz;
    bus.ex_lunsigned_i = uns;
  endtask

  task automatic idle_in();
    bus.ex_valid_i    = 1'b0;
    bus.ex_load_i     = 1'b0;
    bus.data_rvalid_i = 1'b0;
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    chk(tag, {31'b0, bus.stall_o}, {31'b0, exp});
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.ex_valid_i     = 1'b0;
    bus.ex_result_i    = '0;
    bus.ex_rd_i        = '0;
    bus.ex_wen_i       = 1'b0;
    bus.ex_load_i      = 1'b0;
    bus.ex_lsize_i     = 2'b00;
    bus.ex_lunsigned_i = 1'b0;
    bus.data_rvalid_i  = 1'b0;
    bus.data_rdata_i   = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_stall("rst_stall", 1'b0);
    chk("rst_we", {31'b0, bus.write_en_o}, 32'd0);
    chk("rst_waddr", {27'b0, bus.waddr_wb_o}, 32'd0);
    chk("rst_wdata", bus.wdata_wb_o, 32'd0);
    chk("rst_err", {31'b0, bus.load_err_o}, 32'd0);
    rst_n = 1'b1;
    step(1'b0);

    // Back-to-back ALU results.
    drive_alu(5'd5, 32'h0000_1234, 1'b1); push(5'd5, 32'h0000_1234);
    chk_stall("b2b_stall0", 1'b0);
    step(1'b1);
    drive_alu(5'd6, 32'h0000_BEEF, 1'b1); push(5'd6, 32'h0000_BEEF);
    chk_stall("b2b_stall1", 1'b0);
    step(1'b1);

    // x0 write suppressed; data still captured.
    drive_alu(5'd0, 32'hFFFF_FFFF, 1'b1);
    step(1'b0);
    chk("x0_wdata", bus.wdata_wb_o, 32'hFFFF_FFFF);
    chk("x0_waddr", {27'b0, bus.waddr_wb_o}, 32'd0);

    // wen=0 never writes.
    drive_alu(5'd3, 32'h1111_2222, 1'b0);
    step(1'b0);
    idle_in();
    step(1'b0);
    chk("hold_wdata", bus.wdata_wb_o, 32'h1111_2222);

    // Signed byte load, offset 2, response in third wait cycle.
    // An ALU instruction presented during the wait must be ignored.
    drive_load(5'd7, 32'h0000_0102, 2'b00, 1'b0);
    step(1'b0);
    drive_alu(5'd12, 32'hAAAA_AAAA, 1'b1);
    chk_stall("lb_w1", 1'b1); step(1'b0);
    chk_stall("lb_w2", 1'b1); step(1'b0);
    chk_stall("lb_w3", 1'b1);
    idle_in();
    bus.data_rvalid_i = 1'b1; bus.data_rdata_i = 32'h0080_0000;
    push(5'd7, 32'hFFFF_FF80);
    step(1'b1);
    bus.data_rvalid_i = 1'b0;
    chk_stall("lb_done", 1'b0);

    // Same, unsigned.
    drive_load(5'd8, 32'h0000_0102, 2'b00, 1'b1);
    step(1'b0);
    idle_in();
    chk_stall("lbu_w1", 1'b1); step(1'b0);
    chk_stall("lbu_w2", 1'b1); step(1'b0);
    chk_stall("lbu_w3", 1'b1);
    bus.data_rvalid_i = 1'b1; bus.data_rdata_i = 32'h0080_0000;
    push(5'd8, 32'h0000_0080);
    step(1'b1);
    bus.data_rvalid_i = 1'b0;

    // Zero-wait signed half, offset 2, then an ALU op next cycle.
    drive_load(5'd9, 32'h0000_0002, 2'b01, 1'b0);
    bus.data_rvalid_i = 1'b1; bus.data_rdata_i = 32'h8001_0000;
    push(5'd9, 32'hFFFF_8001);
    chk_stall("lh0_stall", 1'b0);
    step(1'b1);
    bus.data_rvalid_i = 1'b0;
    drive_alu(5'd10, 32'h0000_0055, 1'b1); push(5'd10, 32'h0000_0055);
    chk_stall("after_lh0", 1'b0);
    step(1'b1);

    // Zero-wait word, offset 3 ignored.
    drive_load(5'd11, 32'h0000_0003, 2'b10, 1'b0);
    bus.data_rvalid_i = 1'b1; bus.data_rdata_i = 32'hDEAD_BEEF;
    push(5'd11, 32'hDEAD_BEEF);
    step(1'b1);
    // Unsigned half, offset 1 (low bit ignored -> lower half).
    drive_load(5'd13, 32'h0000_0001, 2'b01, 1'b1);
    bus.data_rdata_i = 32'h1234_8765;
    push(5'd13, 32'h0000_8765);
    step(1'b1);
    // Signed byte, offset 3, positive.
    drive_load(5'd14, 32'h0000_0003, 2'b00, 1'b0);
    bus.data_rdata_i = 32'h7F00_00FF;
    push(5'd14, 32'h0000_007F);
    step(1'b1);

    // Stray rvalid in IDLE is ignored.
    idle_in();
    bus.data_rvalid_i = 1'b1;
    step(1'b0);
    bus.data_rvalid_i = 1'b0;

    // Reset during WAIT_LOAD.
    drive_load(5'd15, 32'h0000_0000, 2'b10, 1'b0);
    step(1'b0);
    idle_in();
    chk_stall("rl_wait", 1'b1);
    rst_n = 1'b0;
    #2;
    chk_stall("rl_stall", 1'b0);
    chk("rl_we", {31'b0, bus.write_en_o}, 32'd0);
    chk("rl_waddr", {27'b0, bus.waddr_wb_o}, 32'd0);
    chk("rl_wdata", bus.wdata_wb_o, 32'd0);
    chk("rl_err", {31'b0, bus.load_err_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.data_rvalid_i = 1'b1; bus.data_rdata_i = 32'h5555_5555;
    step(1'b0);
    bus.data_rvalid_i = 1'b0;
    chk_stall("rl_idle", 1'b0);

`ifdef WB_LOAD_TIMEOUT_EN
    // Timeout after 4 wait cycles.
    drive_load(5'd16, 32'h0000_0000, 2'b10, 1'b0);
    step(1'b0);
    idle_in();
    for (int i = 0; i < 4; i++) begin
      chk_stall("to_wait", 1'b1);
      chk("to_err_early", {31'b0, bus.load_err_o}, 32'd0);
      step(1'b0);
    end
    chk("to_err", {31'b0, bus.load_err_o}, 32'd1);
    chk_stall("to_stall_drop", 1'b0);
    step(1'b0);
    chk("to_err_pulse", {31'b0, bus.load_err_o}, 32'd0);

    // Response in the 4th wait cycle wins.
    drive_load(5'd17, 32'h0000_0000, 2'b10, 1'b0);
    step(1'b0);
    idle_in();
    for (int i = 0; i < 3; i++) step(1'b0);
    chk_stall("tw_wait4", 1'b1);
    bus.data_rvalid_i = 1'b1; bus.data_rdata_i = 32'hCAFE_F00D;
    push(5'd17, 32'hCAFE_F00D);
    step(1'b1);
    bus.data_rvalid_i = 1'b0;
    chk("tw_err", {31'b0, bus.load_err_o}, 32'd0);
    chk_stall("tw_stall", 1'b0);
`endif

    step(1'b0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_wb_stage
`default_nettype wire

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the ri5cy pipeline. It drives the register-bank write port of the decode stage: `waddr_wb`, `wdata_wb` and the write enable. It takes retiring results from the execute/memory side and holds the pipeline while a load waits for data memory. It also aligns and sign- or zero-extends load data before the write.

## Interface
Parameters:
- `WORD_WIDTH`, 32: data word width.
- `ADDR_WIDTH`, 5: register address width.
- `TIMEOUT_CYCLES`, 16: load-response timeout. Used only when the timeout feature is enabled.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ex_valid_i`  in  1  a retiring instruction is presented this cycle.
- `ex_result_i`  in  WORD_WIDTH  ALU/MD result, or the load effective address for loads.
- `ex_rd_i`  in  ADDR_WIDTH  destination register.
- `ex_wen_i`  in  1  the instruction writes rd.
- `ex_load_i`  in  1  the instruction is a load.
- `ex_lsize_i`  in  2  load size: 00 byte, 01 half, 10 word (11 treated as word).
- `ex_lunsigned_i`  in  1  zero-extend instead of sign-extend.
- `data_rvalid_i`  in  1  data memory response valid.
- `data_rdata_i`  in  WORD_WIDTH  data memory read word, aligned to a 32-bit word.
- `stall_o`  out  1  hold upstream; the instruction presented is not accepted.
- `waddr_wb_o`  out  ADDR_WIDTH  register write address.
- `wdata_wb_o`  out  WORD_WIDTH  register write data.
- `write_en_o`  out  1  register write strobe, one cycle per write.
- `load_err_o`  out  1  one-cycle pulse on load timeout.

## Operation
- FSM states: IDLE and WAIT_LOAD. Reset enters IDLE.
- IDLE, `ex_valid_i`=1, non-load:
  - capture rd and result;
  - next cycle drive `write_en_o`=`ex_wen_i && ex_rd_i!=0`;
  - stay in IDLE.
- IDLE, `ex_valid_i`=1, load: capture rd, wen, size, unsigned flag and `ex_result_i[1:0]` as byte offset.
  - If `data_rvalid_i`=1 in the same cycle, format the data and write next cycle; stay in IDLE.
  - Otherwise go to WAIT_LOAD.
- WAIT_LOAD:
  - `stall_o`=1; `ex_valid_i` is ignored.
  - On `data_rvalid_i`=1: format the data, write next cycle, return to IDLE. `stall_o` falls in that same cycle.
- Load formatting:
  - Byte: select byte `rdata[8*off +: 8]`.
  - Half: select `rdata[16*off[1] +: 16]`; `off[0]` is ignored.
  - Word: use the full word and ignore the offset.
  - Extend byte/half results with sign or zero according to `ex_lunsigned_i`.
- Writes to x0 never assert `write_en_o`. The captured data still appears on `wdata_wb_o`.
- `data_rvalid_i` in IDLE without a load being accepted is ignored: no write, no error.
- `stall_o` = (state == WAIT_LOAD). It is combinational from state only and does not depend on any input.

## Timing
- Reset values: `stall_o`=0, `write_en_o`=0, `waddr_wb_o`=0, `wdata_wb_o`=0, `load_err_o`=0; FSM in IDLE; timeout counter 0.
- Reset mid-load: return to IDLE immediately. The pending write is discarded; no write and no error.
- `waddr_wb_o`, `wdata_wb_o`, `write_en_o` and `load_err_o` are registered. `write_en_o` is high for exactly one cycle per retiring write.
- Latency:
  - non-load: 1 cycle from acceptance to `write_en_o`;
  - load: 1 cycle after the `data_rvalid_i` cycle.
- Throughput: one non-load instruction per cycle, back-to-back.
- A zero-wait load followed by another instruction on the next cycle is accepted without stall.
- `waddr_wb_o` and `wdata_wb_o` hold their last value when `write_en_o`=0.

## Configuration
- Macro: `WB_LOAD_TIMEOUT_EN`.
- Defined:
  - a counter of width `$clog2(TIMEOUT_CYCLES+1)` clears on entry to WAIT_LOAD and increments each WAIT_LOAD cycle without `data_rvalid_i`;
  - when the count reaches `TIMEOUT_CYCLES`, return to IDLE with no register write and pulse `load_err_o` for 1 cycle (registered);
  - `data_rvalid_i` in the same cycle as the timeout wins: normal write, no error.
- Not defined: WAIT_LOAD waits indefinitely. `load_err_o` is tied 0 and no counter is instantiated.

## Structure
- Shared package `riscv_defines` holds:
  - `WORD_WIDTH` and `ADDR_WIDTH`;
  - load-size encodings `LSIZE_BYTE`, `LSIZE_HALF`, `LSIZE_WORD`;
  - the FSM state enum `wb_state_e`.
- One sub-module, `load_align`: purely combinational, maps (rdata, offset, size, unsigned) to the extended word. It is reusable by the LSU.

## Test plan
- Non-load back-to-back: valid rd=5 result=0x1234, then rd=6 result=0xBEEF.
  - `write_en_o` is 1 on two consecutive cycles with (5,0x1234) then (6,0xBEEF); `stall_o` stays 0.
- x0 suppression: valid rd=0 wen=1 result=0xFFFF_FFFF -> `write_en_o` stays 0.
- Load byte, signed, offset 2, rdata=0x0080_0000, rvalid 3 cycles after accept:
  - `stall_o`=1 for 3 cycles;
  - then write rd with 0xFFFF_FF80.
  - Same stimulus with the unsigned flag writes 0x0000_0080.
- Zero-wait half load, offset 2, rdata=0x8001_0000, rvalid in the accept cycle:
  - no stall;
  - write 0xFFFF_8001 next cycle.
- Reset asserted during WAIT_LOAD, with rvalid after reset release:
  - no write;
  - all outputs read 0 and the FSM is in IDLE.
- With `WB_LOAD_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, no rvalid:
  - `load_err_o` pulses once;
  - `stall_o` drops;
  - no write.
  - Same stimulus with rvalid in the 4th wait cycle: normal write, no error.
